// File: rtl/casu_mr.sv
// casu_mr: multi-region runtime monitor for the openMSP430.
// Watches the PC, CPU data writes and DMA writes. Raises a registered reset
// request whenever execution leaves trusted code or the enabled executable
// regions, or a protected range is written illegally.
module casu_mr #(
  parameter int            AW            = 16,
  parameter int            N_ER          = 2,
  parameter int            IW            = 1,
  parameter logic [AW-1:0] SMEM_BASE     = 16'hA000,
  parameter logic [AW-1:0] SMEM_SIZE     = 16'h4000,
  parameter logic [AW-1:0] SCACHE_BASE   = 16'hFFDF,
  parameter logic [AW-1:0] SCACHE_SIZE   = 16'h0033,
  parameter logic [AW-1:0] EP_BASE       = 16'h0140,
  parameter logic [AW-1:0] EP_SIZE       = 16'h0003,
  parameter logic [AW-1:0] RESET_HANDLER = 16'h0000,
  parameter int            HOLD_CYCLES   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  input  logic          data_wr,
  input  logic [AW-1:0] data_addr,
  input  logic          dma_en,
  input  logic [AW-1:0] dma_addr,
  input  logic          cfg_wr,
  input  logic [IW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_min,
  input  logic [AW-1:0] cfg_max,
  input  logic          cfg_en,
  output logic          reset,
  output logic [2:0]    viol_cause,
  output logic [7:0]    viol_cnt,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    KILL_HOLD = 2'd0,
    KILL_WAIT = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  // Fixed range test: [base, base+size-2], top computed one bit wider so a
  // range touching the top of the address space does not wrap.
  function automatic logic in_range(input logic [AW-1:0] addr,
                                    input logic [AW-1:0] base,
                                    input logic [AW-1:0] size);
    logic [AW:0] top;
    top = {1'b0, base} + {1'b0, size} - (AW+1)'(2);
    return (size >= AW'(2)) && (addr >= base) && ({1'b0, addr} <= top);
  endfunction

  state_t        state;
  logic [HW-1:0] hold_cnt;

  logic [AW-1:0] er_min [N_ER];
  logic [AW-1:0] er_max [N_ER];
  logic          er_en  [N_ER];

  logic          pc_in_casu;
  logic          pc_in_er;
  logic          data_in_er;
  logic          dma_in_er;
  logic          data_in_p;
  logic          dma_in_p;
  logic [2:0]    cause;
  logic          violation;

  // Region membership against the currently stored ER bounds.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pc_in_er   = 1'b0;
    data_in_er = 1'b0;
    dma_in_er  = 1'b0;
    for (int i = 0; i < N_ER; i++) begin
      if (er_en[i] && pc >= er_min[i] && pc <= er_max[i])               pc_in_er   = 1'b1;
      if (er_en[i] && data_addr >= er_min[i] && data_addr <= er_max[i]) data_in_er = 1'b1;
      if (er_en[i] && dma_addr >= er_min[i] && dma_addr <= er_max[i])   dma_in_er  = 1'b1;
    end
  end

  assign pc_in_casu = in_range(pc, SMEM_BASE, SMEM_SIZE);
  assign data_in_p  = data_in_er
                    || in_range(data_addr, SCACHE_BASE, SCACHE_SIZE)
                    || in_range(data_addr, EP_BASE, EP_SIZE);
  assign dma_in_p   = dma_in_er
                    || in_range(dma_addr, SCACHE_BASE, SCACHE_SIZE)
                    || in_range(dma_addr, EP_BASE, EP_SIZE);

  // Violation cause; assignments run from highest code to lowest so the
  // lowest firing code wins.
  always_comb begin
    cause = 3'd0;
    if (cfg_wr && !pc_in_casu)                             cause = 3'd4;
    if (!pc_in_casu && !pc_in_er && pc != RESET_HANDLER)   cause = 3'd3;
    if (dma_en && dma_in_p)                                cause = 3'd2;
    if (data_wr && data_in_p && !pc_in_casu)               cause = 3'd1;
  end

  assign violation = (cause != 3'd0);

  // ER configuration registers: only trusted code may load them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: these small register arrays have defined reset values (all regions disabled and empty), so they are reset unlike a RAM.
      for (int i = 0; i < N_ER; i++) begin
        er_min[i] <= '1;
        er_max[i] <= '0;
        er_en[i]  <= 1'b0;
      end
    end else if (cfg_wr && pc_in_casu) begin
      for (int i = 0; i < N_ER; i++) begin
        if (cfg_idx == IW'(i)) begin
          er_min[i] <= cfg_min;
          er_max[i] <= cfg_max;
          er_en[i]  <= cfg_en;
        end
      end
    end
  end

  // Monitor FSM with registered reset request, cause latch and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= KILL_HOLD;
      hold_cnt   <= HOLD_INIT;
      reset      <= 1'b1;
      viol_cause <= 3'd0;
      viol_cnt   <= 8'd0;
    end else begin
      case (state)
        KILL_HOLD: begin
          reset <= 1'b1;
          if (hold_cnt == '0) state    <= KILL_WAIT;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        KILL_WAIT: begin
          if (pc == RESET_HANDLER && !violation) begin
            state <= RUN;
            reset <= 1'b0;
          end
        end
        RUN: begin
          if (violation) begin
            state      <= KILL_HOLD;
            hold_cnt   <= HOLD_INIT;
            reset      <= 1'b1;
            viol_cause <= cause;
            if (viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
          end
        end
        default: begin
          state    <= KILL_HOLD;
          hold_cnt <= HOLD_INIT;
          reset    <= 1'b1;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
